// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard controller: forwarding select encodings,
// the default register-index width and type, and the forwarding priority helper.
package hazard_pkg;
  localparam int REG_AW_DEF = 5;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef logic [REG_AW_DEF-1:0] reg_idx_t;

  // Memory stage holds the younger result, so it wins over Writeback.
  function automatic logic [1:0] fwd_sel(input logic hit_m, input logic hit_w);
    if (hit_m)      return FWD_M;
    else if (hit_w) return FWD_W;
    else            return FWD_RF;
  endfunction
endpackage

// File: rtl/md_scoreboard.sv
// Single-entry scoreboard for one outstanding mul/div result: busy counter,
// completion pulse, and the RAW / structural stall requests it raises.
module md_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue,
  input  logic [REG_AW-1:0] rd_issue,
  input  logic [REG_AW-1:0] rs1D,
  input  logic [REG_AW-1:0] rs2D,
  input  logic              mdD,
  output logic              busy,
  output logic              done,
  output logic              stall
);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MD_LAT - 1);

  logic [REG_AW-1:0] md_rd;
  logic [CNT_W-1:0]  md_cnt;
  logic              last;
  logic              raw;
  logic              struc;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      md_rd  <= '0;
      md_cnt <= '0;
    end else if (issue) begin
      // Also covers a reload in the final busy cycle.
      busy   <= 1'b1;
      md_rd  <= rd_issue;
      md_cnt <= CNT_INIT;
    end else if (busy) begin
      if (md_cnt == '0) busy   <= 1'b0;
      else              md_cnt <= md_cnt - 1'b1;
    end
  end

  assign last  = busy && (md_cnt == '0);
  assign done  = last && !rst;
  assign raw   = busy && (md_rd != '0) && ((rs1D == md_rd) || (rs2D == md_rd));
  assign struc = busy && mdD && !last;
  assign stall = raw || struc;
endmodule

// File: rtl/hazard_ctrl_sb.sv
// Hazard controller: EX forwarding selects, multi-cycle load-use stalls,
// mul/div scoreboard stalls and branch flushes for the 5-stage core.
module hazard_ctrl_sb
  import hazard_pkg::*;
#(
  parameter int REG_AW     = REG_AW_DEF,
  parameter int LOAD_STALL = 1,
  parameter int MD_LAT     = 4,
  parameter int CNT_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1D,
  input  logic [REG_AW-1:0] rs2D,
  input  logic              mdD,
  input  logic [REG_AW-1:0] rs1E,
  input  logic [REG_AW-1:0] rs2E,
  input  logic [REG_AW-1:0] rdE,
  input  logic              loadE,
  input  logic              mdIssueE,
  input  logic              pcsrcE,
  input  logic [REG_AW-1:0] rdM,
  input  logic              regwrM,
  input  logic [REG_AW-1:0] rdW,
  input  logic              regwrW,
  output logic [1:0]        forwardAE,
  output logic [1:0]        forwardBE,
  output logic              stallF,
  output logic              stallD,
  output logic              flushD,
  output logic              flushE,
  output logic              mdBusy,
  output logic              mdDone
);
  localparam logic [CNT_W-1:0] LU_INIT = CNT_W'(LOAD_STALL - 1);

  logic [CNT_W-1:0] lu_cnt;
  logic             lu_hit;
  logic             lu_stall;
  logic             md_stall;
  logic             any_stall;
  logic             md_issue;

  always_comb begin
    forwardAE = fwd_sel((rs1E == rdM) && regwrM && (rs1E != '0),
                        (rs1E == rdW) && regwrW && (rs1E != '0));
    forwardBE = fwd_sel((rs2E == rdM) && regwrM && (rs2E != '0),
                        (rs2E == rdW) && regwrW && (rs2E != '0));
  end

  assign lu_hit   = loadE && (rdE != '0) && ((rdE == rs1D) || (rdE == rs2D));
  // Once counting, the load has left EX, so the comparator no longer matters.
  assign lu_stall = (lu_cnt != '0) || lu_hit;

  always_ff @(posedge clk) begin
    if (rst || pcsrcE)       lu_cnt <= '0;
    else if (lu_cnt != '0)   lu_cnt <= lu_cnt - 1'b1;
    else if (lu_hit)         lu_cnt <= LU_INIT;
  end

  assign md_issue = mdIssueE && !pcsrcE && !flushE;

  md_scoreboard #(
    .REG_AW (REG_AW),
    .MD_LAT (MD_LAT),
    .CNT_W  (CNT_W)
  ) u_md (
    .clk      (clk),
    .rst      (rst),
    .issue    (md_issue),
    .rd_issue (rdE),
    .rs1D     (rs1D),
    .rs2D     (rs2D),
    .mdD      (mdD),
    .busy     (mdBusy),
    .done     (mdDone),
    .stall    (md_stall)
  );

  assign any_stall = lu_stall || md_stall;
  // A taken branch must let the PC load its target, so it overrides holds.
  assign stallF = any_stall && !pcsrcE && !rst;
  assign stallD = any_stall && !pcsrcE && !rst;
  assign flushD = pcsrcE && !rst;
  assign flushE = (any_stall || pcsrcE) && !rst;
endmodule

// File: tb/tb_hazard_ctrl_sb.sv
// Scoreboard bench for hazard_ctrl_sb (LOAD_STALL=3, MD_LAT=4): directed
// vectors push hand-computed outputs; a negedge monitor pops and compares.
module tb_hazard_ctrl_sb;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic          mdD, loadE, mdIssueE, pcsrcE, regwrM, regwrW;
  logic [1:0]    forwardAE, forwardBE;
  logic          stallF, stallD, flushD, flushE, mdBusy, mdDone;

  typedef struct {
    string      name;
    logic [9:0] v;
  } exp_t;

  exp_t q[$];
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  hazard_ctrl_sb #(
    .REG_AW     (AW),
    .LOAD_STALL (3),
    .MD_LAT     (4),
    .CNT_W      (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rs1D      (rs1D),
    .rs2D      (rs2D),
    .mdD       (mdD),
    .rs1E      (rs1E),
    .rs2E      (rs2E),
    .rdE       (rdE),
    .loadE     (loadE),
    .mdIssueE  (mdIssueE),
    .pcsrcE    (pcsrcE),
    .rdM       (rdM),
    .regwrM    (regwrM),
    .rdW       (rdW),
    .regwrW    (regwrW),
    .forwardAE (forwardAE),
    .forwardBE (forwardBE),
    .stallF    (stallF),
    .stallD    (stallD),
    .flushD    (flushD),
    .flushE    (flushE),
    .mdBusy    (mdBusy),
    .mdDone    (mdDone)
  );

  // {fwdA, fwdB, stallF, stallD, flushD, flushE, mdBusy, mdDone}
  function automatic logic [9:0] ex(input logic [1:0] fa, input logic [1:0] fb,
                                    input logic st, input logic fd, input logic fe,
                                    input logic busy, input logic done);
    return {fa, fb, st, st, fd, fe, busy, done};
  endfunction

  task automatic chk(input string nm, input logic [9:0] v);
    exp_t e;
    e.name = nm;
    e.v    = v;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rs1D = '0; rs2D = '0; rs1E = '0; rs2E = '0; rdE = '0; rdM = '0; rdW = '0;
    mdD = 1'b0; loadE = 1'b0; mdIssueE = 1'b0; pcsrcE = 1'b0;
    regwrM = 1'b0; regwrW = 1'b0;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [9:0] act;
      e   = q.pop_front();
      act = {forwardAE, forwardBE, stallF, stallD, flushD, flushE, mdBusy, mdDone};
      total++;
      if (act === e.v) passed++;
      else $display("FAIL %s: got %b expected %b", e.name, act, e.v);
    end
  end

  initial begin
    rst = 1'b1;
    clr();
    repeat (2) @(posedge clk);
    #1;

    // reset gating
    loadE = 1; rdE = 7; rs1D = 7; pcsrcE = 1; mdD = 1;
    chk("rst_gate", ex(2'b00, 2'b00, 0, 0, 0, 0, 0));
    rst = 1'b0; clr();
    chk("idle", ex(2'b00, 2'b00, 0, 0, 0, 0, 0));

    // forwarding
    rs1E = 5; rdM = 5; regwrM = 1; rdW = 5; regwrW = 1;
    chk("fwd_m_prio", ex(2'b10, 2'b00, 0, 0, 0, 0, 0));
    rs1E = 0;
    chk("fwd_x0", ex(2'b00, 2'b00, 0, 0, 0, 0, 0));
    rs1E = 3; rs2E = 6; rdM = 6; regwrM = 1; rdW = 3; regwrW = 1;
    chk("fwd_mix", ex(2'b01, 2'b10, 0, 0, 0, 0, 0));
    rs1E = 6; rs2E = 3; rdM = 6; regwrM = 0; rdW = 6; regwrW = 1;
    chk("fwd_nowr", ex(2'b01, 2'b00, 0, 0, 0, 0, 0));
    clr();

    // load-use: exactly 3 bubbles
    loadE = 1; rdE = 7; rs2D = 7;
    chk("lu_1", ex(2'b00, 2'b00, 1, 0, 1, 0, 0));
    loadE = 0; rdE = 0;
    chk("lu_2", ex(2'b00, 2'b00, 1, 0, 1, 0, 0));
    chk("lu_3", ex(2'b00, 2'b00, 1, 0, 1, 0, 0));
    chk("lu_end", ex(2'b00, 2'b00, 0, 0, 0, 0, 0));
    clr();
    loadE = 1; rdE = 0; rs1D = 0;
    chk("lu_x0", ex(2'b00, 2'b00, 0, 0, 0, 0, 0));
    clr();

    // branch during load-use countdown
    loadE = 1; rdE = 4; rs1D = 4;
    chk("lubr_1", ex(2'b00, 2'b00, 1, 0, 1, 0, 0));
    loadE = 0; rdE = 0; pcsrcE = 1;
    chk("lubr_br", ex(2'b00, 2'b00, 0, 1, 1, 0, 0));
    pcsrcE = 0;
    chk("lubr_end", ex(2'b00, 2'b00, 0, 0, 0, 0, 0));
    clr();

    // mul/div RAW
    mdIssueE = 1; rdE = 9;
    chk("md_issue", ex(2'b00, 2'b00, 0, 0, 0, 0, 0));
    mdIssueE = 0; rdE = 0; rs1D = 9;
    chk("md_raw1", ex(2'b00, 2'b00, 1, 0, 1, 1, 0));
    chk("md_raw2", ex(2'b00, 2'b00, 1, 0, 1, 1, 0));
    chk("md_raw3", ex(2'b00, 2'b00, 1, 0, 1, 1, 0));
    chk("md_rawdone", ex(2'b00, 2'b00, 1, 0, 1, 1, 1));
    chk("md_release", ex(2'b00, 2'b00, 0, 0, 0, 0, 0));
    clr();

    // structural stall and back-to-back issue in the done cycle
    mdIssueE = 1; rdE = 12;
    chk("st_issue", ex(2'b00, 2'b00, 0, 0, 0, 0, 0));
    mdIssueE = 0; rdE = 0; mdD = 1; rs1D = 1; rs2D = 2;
    chk("st_1", ex(2'b00, 2'b00, 1, 0, 1, 1, 0));
    chk("st_2", ex(2'b00, 2'b00, 1, 0, 1, 1, 0));
    chk("st_3", ex(2'b00, 2'b00, 1, 0, 1, 1, 0));
    mdIssueE = 1; rdE = 13;
    chk("st_done_reissue", ex(2'b00, 2'b00, 0, 0, 0, 1, 1));
    mdIssueE = 0; rdE = 0; mdD = 0; rs1D = 13; rs2D = 0;
    chk("st_new_rd", ex(2'b00, 2'b00, 1, 0, 1, 1, 0));
    rs1D = 12;
    chk("st_old_rd", ex(2'b00, 2'b00, 0, 0, 0, 1, 0));
    rs1D = 0; rs2D = 13; pcsrcE = 1;
    chk("st_br_keep", ex(2'b00, 2'b00, 0, 1, 1, 1, 0));
    pcsrcE = 0; rs2D = 0;
    chk("st_done2", ex(2'b00, 2'b00, 0, 0, 0, 1, 1));
    clr();

    // issue squashed by a taken branch
    mdIssueE = 1; rdE = 5; pcsrcE = 1;
    chk("md_br_issue", ex(2'b00, 2'b00, 0, 1, 1, 0, 0));
    clr();
    chk("md_no_entry", ex(2'b00, 2'b00, 0, 0, 0, 0, 0));

    // rd=0 issue: busy but no RAW
    mdIssueE = 1; rdE = 0;
    chk("md_x0_issue", ex(2'b00, 2'b00, 0, 0, 0, 0, 0));
    clr();
    chk("md_x0_noraw", ex(2'b00, 2'b00, 0, 0, 0, 1, 0));

    // reset mid-operation
    loadE = 1; rdE = 8; rs1D = 8;
    chk("rst_pre", ex(2'b00, 2'b00, 1, 0, 1, 1, 0));
    loadE = 0; rdE = 0; rst = 1;
    chk("rst_mid", ex(2'b00, 2'b00, 0, 0, 0, 1, 0));
    rst = 0;
    chk("rst_after", ex(2'b00, 2'b00, 0, 0, 0, 0, 0));
    clr();
    chk("rst_idle", ex(2'b00, 2'b00, 0, 0, 0, 0, 0));

    // load-use and md RAW overlapping
    mdIssueE = 1; rdE = 10;
    chk("ov_issue", ex(2'b00, 2'b00, 0, 0, 0, 0, 0));
    mdIssueE = 0; loadE = 1; rdE = 11; rs1D = 10; rs2D = 11;
    chk("ov_1", ex(2'b00, 2'b00, 1, 0, 1, 1, 0));
    loadE = 0; rdE = 0;
    chk("ov_2", ex(2'b00, 2'b00, 1, 0, 1, 1, 0));
    chk("ov_3", ex(2'b00, 2'b00, 1, 0, 1, 1, 0));
    chk("ov_done", ex(2'b00, 2'b00, 1, 0, 1, 1, 1));
    chk("ov_end", ex(2'b00, 2'b00, 0, 0, 0, 0, 0));
    clr();

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      total++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
